// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, data base offset and grant encoding for the memory port arbiter
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 8;
  localparam int ARB_DATA_W = 8;
  localparam logic [ARB_ADDR_W-1:0] ARB_DATA_BASE = 8'd128;

  // Width of the fetch starvation counter; limits up to 15 fit.
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating counter of consecutive lost fetch arbitrations
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int W = STARVE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_at_limit
);

  logic [W-1:0] r_cnt;

  // Clear dominates; increments stop once the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == i_limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by instruction fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W       = ARB_ADDR_W,
  parameter int                DATA_W       = ARB_DATA_W,
  parameter logic [ADDR_W-1:0] DATA_BASE    = ARB_DATA_BASE,
  parameter int                STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  gnt_e                w_gnt;
  logic                w_i_valid;
  logic                w_at_limit;
  logic                w_cnt_clr;
  logic                w_cnt_inc;
  logic [STARVE_W-1:0] w_starve_cnt;
  logic [ADDR_W-1:0]   w_d_paddr;
  logic                r_pend_i;
  logic                r_pend_d;

  // A flushed fetch is treated as absent so it can never be granted.
  assign w_i_valid = i_req & ~i_flush;

  // Data side is relocated into the data segment, wrapping modulo memory size.
  assign w_d_paddr = d_addr + DATA_BASE;

  // Pick the winner: data by default, fetch once it has lost LIMIT times in a row.
  always_comb begin
    w_gnt = GNT_NONE;
    if (rst_n) begin
      if (w_i_valid && d_req) begin
        w_gnt = w_at_limit ? GNT_I : GNT_D;
      end else if (w_i_valid) begin
        w_gnt = GNT_I;
      end else if (d_req) begin
        w_gnt = GNT_D;
      end
    end
  end

  // Drive the memory port and grant strobes from the chosen winner.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (w_gnt)
      GNT_I: begin
        i_gnt  = 1'b1;
        m_en   = 1'b1;
        m_addr = i_addr;
      end
      GNT_D: begin
        d_gnt  = 1'b1;
        m_en   = 1'b1;
        m_we   = d_we;
        m_addr = w_d_paddr;
        if (d_we) begin
          m_wdata = d_wdata;
        end
      end
      default: begin
      end
    endcase
  end

  assign w_cnt_clr = ~i_req | i_flush | (w_gnt == GNT_I);
  assign w_cnt_inc = i_req & (w_gnt == GNT_D);

  starve_counter #(
    .W (STARVE_W)
  ) u_starve_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .i_limit    (LIMIT),
    .o_cnt      (w_starve_cnt),
    .o_at_limit (w_at_limit)
  );

  // Remember which side issued a read so next cycle's m_rdata is routed to it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_i <= 1'b0;
      r_pend_d <= 1'b0;
    end else begin
      r_pend_i <= (w_gnt == GNT_I);
      r_pend_d <= (w_gnt == GNT_D) & ~d_we;
    end
  end

  // A flush arriving alongside the response discards it.
  assign i_rvalid = r_pend_i & ~i_flush;
  assign d_rvalid = r_pend_d;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_req, i_flush, i_gnt, i_rvalid;
  logic [7:0] i_addr, i_rdata;
  logic       d_req, d_we, d_gnt, d_rvalid;
  logic [7:0] d_addr, d_wdata, d_rdata;
  logic       m_en, m_we;
  logic [7:0] m_addr, m_wdata;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (8),
    .DATA_W       (8),
    .DATA_BASE    (8'd128),
    .STARVE_LIMIT (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_flush  (i_flush),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // Registered single-port memory model.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [7:0] ia, input logic fl,
                       input logic dr, input logic we, input logic [7:0] da,
                       input logic [7:0] wd);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; i_flush = fl;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[5]   = 8'hA5;
    mem[131] = 8'h5A;
    mem[128] = 8'h77;
    mem[1]   = 8'h11;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 8'd9, 0, 1, 0, 0, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_cnt", dut.w_starve_cnt, 0);

    // Lone fetch
    rst_n = 1'b1;
    drive(1, 8'd5, 0, 0, 0, 0, 0);
    chk("fetch_gnt", i_gnt, 1);
    chk("fetch_d_gnt", d_gnt, 0);
    chk("fetch_m_en", m_en, 1);
    chk("fetch_m_we", m_we, 0);
    chk("fetch_m_addr", m_addr, 5);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fetch_rvalid", i_rvalid, 1);
    chk("fetch_rdata", i_rdata, 8'hA5);
    chk("fetch_d_rvalid", d_rvalid, 0);
    chk("idle_m_en", m_en, 0);

    // Data read with offset
    drive(0, 0, 0, 1, 0, 8'd3, 0);
    chk("dread_gnt", d_gnt, 1);
    chk("dread_m_addr", m_addr, 131);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("dread_rvalid", d_rvalid, 1);
    chk("dread_rdata", d_rdata, 8'h5A);
    chk("dread_i_rvalid", i_rvalid, 0);

    // Write with wrap, then fetch of the written physical address
    drive(0, 0, 0, 1, 1, 8'd200, 8'h3C);
    chk("wr_gnt", d_gnt, 1);
    chk("wr_m_we", m_we, 1);
    chk("wr_m_addr", m_addr, 72);
    chk("wr_m_wdata", m_wdata, 8'h3C);
    drive(1, 8'd72, 0, 0, 0, 0, 0);
    chk("wr_no_rvalid", d_rvalid, 0);
    chk("wrfetch_gnt", i_gnt, 1);
    chk("wrfetch_m_addr", m_addr, 72);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wrfetch_rvalid", i_rvalid, 1);
    chk("wrfetch_rdata", i_rdata, 8'h3C);

    // Starvation: pattern D,D,D,I,D,D,D,I with counter 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      drive(1, 8'd1, 0, 1, 0, 8'd0, 0);
      chk($sformatf("starve_cnt_%0d", k), dut.w_starve_cnt, k % 4);
      chk($sformatf("starve_i_gnt_%0d", k), i_gnt, (k % 4) == 3);
      chk($sformatf("starve_d_gnt_%0d", k), d_gnt, (k % 4) != 3);
      chk($sformatf("starve_m_addr_%0d", k), m_addr, ((k % 4) == 3) ? 1 : 128);
      if (k > 0) begin
        chk($sformatf("starve_i_rv_%0d", k), i_rvalid, ((k - 1) % 4) == 3);
        chk($sformatf("starve_d_rv_%0d", k), d_rvalid, ((k - 1) % 4) != 3);
        chk($sformatf("starve_rdata_%0d", k), m_rdata, (((k - 1) % 4) == 3) ? 8'h11 : 8'h77);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("starve_last_i_rv", i_rvalid, 1);
    chk("starve_last_rdata", i_rdata, 8'h11);
    chk("starve_cnt_after", dut.w_starve_cnt, 0);

    // Flush kills the fetch response and lets data through
    drive(1, 8'd5, 0, 0, 0, 0, 0);
    chk("fl_i_gnt", i_gnt, 1);
    drive(1, 8'd5, 1, 1, 0, 8'd3, 0);
    chk("fl_i_gnt_blocked", i_gnt, 0);
    chk("fl_i_rvalid", i_rvalid, 0);
    chk("fl_d_gnt", d_gnt, 1);
    chk("fl_m_addr", m_addr, 131);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl_d_rvalid", d_rvalid, 1);
    chk("fl_d_rdata", d_rdata, 8'h5A);
    chk("fl_i_rvalid2", i_rvalid, 0);
    drive(1, 8'd5, 1, 0, 0, 0, 0);
    chk("fl_only_m_en", m_en, 0);
    chk("fl_only_i_gnt", i_gnt, 0);

    // Reset mid-operation
    drive(1, 8'd5, 0, 1, 0, 8'd3, 0);
    chk("rm_d_gnt0", d_gnt, 1);
    chk("rm_cnt0", dut.w_starve_cnt, 0);
    drive(1, 8'd5, 0, 1, 0, 8'd3, 0);
    chk("rm_d_gnt1", d_gnt, 1);
    chk("rm_cnt1", dut.w_starve_cnt, 1);
    chk("rm_d_rvalid1", d_rvalid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rm_gnt_forced", d_gnt, 0);
    chk("rm_m_en_forced", m_en, 0);
    drive(1, 8'd5, 0, 1, 1, 8'd3, 8'hFF);
    chk("rm_d_rvalid", d_rvalid, 0);
    chk("rm_i_rvalid", i_rvalid, 0);
    chk("rm_cnt", dut.w_starve_cnt, 0);
    chk("rm_i_gnt", i_gnt, 0);
    chk("rm_d_gnt", d_gnt, 0);
    chk("rm_m_we", m_we, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("post_d_rvalid", d_rvalid, 0);
    chk("post_m_en", m_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
